// File: rtl/flasher_pkg.sv
// Shared definitions for the light-flasher: one-hot master FSM state codes
// and the default timing parameters of the flash sequencer.
package flasher_pkg;

   localparam int STATE_W = 6;

   localparam logic [STATE_W-1:0] STATE_OFF1 = 6'b000001;
   localparam logic [STATE_W-1:0] STATE_ON   = 6'b000010;
   localparam logic [STATE_W-1:0] STATE_OFF2 = 6'b000100;
   localparam logic [STATE_W-1:0] STATE_F1   = 6'b001000;
   localparam logic [STATE_W-1:0] STATE_OFF3 = 6'b010000;
   localparam logic [STATE_W-1:0] STATE_F2   = 6'b100000;

   localparam int PHASE_TICKS_DEF = 16;
   localparam int RATE_W_DEF      = 3;

   // True only for exactly one of the six legal state codes.
   function automatic logic state_is_valid(input logic [STATE_W-1:0] s);
      logic v;
      case (s)
         STATE_OFF1, STATE_ON, STATE_OFF2,
         STATE_F1, STATE_OFF3, STATE_F2: v = 1'b1;
         default:                        v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/flash_sequencer_tick_counter.sv
// Resettable register primitive plus the enable-driven terminal counter
// used for both the phase timer and the blink divider.
module dffr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Plain register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

module tick_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] count,
   output logic         done
);

   logic [W-1:0] count_d_s;

   // >= rather than == so a terminal lowered mid-count still ends the count.
   assign done = en & (count >= terminal);

   // Next count: clear wins, terminal restarts from zero, otherwise step on en.
   always_comb begin
      count_d_s = count;
      if (clr) begin
         count_d_s = '0;
      end else if (done) begin
         count_d_s = '0;
      end else if (en) begin
         count_d_s = count + W'(1);
      end else begin
         count_d_s = count;
      end
   end

   dffr #(.W(W)) u_count_reg (
      .clk   (clk),
      .reset (reset),
      .d     (count_d_s),
      .q     (count)
   );

endmodule

// File: rtl/flash_sequencer.sv
// Phase timer and blink generator for the light-flasher master FSM: emits the
// one-cycle next pulse after each phase and drives the LED.
module flash_sequencer
   import flasher_pkg::*;
#(
   parameter int PHASE_TICKS = PHASE_TICKS_DEF,
   parameter int PHASE_W     = 16,
   parameter int RATE_W      = RATE_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               hold,
   input  logic [STATE_W-1:0] state,
   input  logic [RATE_W-1:0]  f1_rate,
   input  logic [RATE_W-1:0]  f2_rate,
   output logic               next,
   output logic               light
);

   localparam int BLINK_W = (1 << RATE_W) - 1;

   logic               state_valid_s;
   logic               flash_s;
   logic               etick_s;
   logic [PHASE_W-1:0] phase_cnt_s;
   logic               phase_done_s;
   logic [RATE_W-1:0]  rate_s;
   logic [BLINK_W-1:0] blink_term_s;
   logic [BLINK_W-1:0] blink_cnt_s;
   logic               blink_done_s;
   logic               blink_clr_s;
   logic               next_r;
   logic               blink_q_r;

   assign state_valid_s = state_is_valid(state);
   assign flash_s       = (state == STATE_F1) | (state == STATE_F2);
   assign etick_s       = tick & ~hold & state_valid_s;
   // Each flash phase restarts lit, including the cycle the FSM is told to advance.
   assign blink_clr_s   = ~flash_s | next_r;

   // Blink rate selection and its terminal count (2^rate - 1).
   always_comb begin
      if (state == STATE_F1) begin
         rate_s = f1_rate;
      end else begin
         rate_s = f2_rate;
      end
      blink_term_s = BLINK_W'((32'd1 << rate_s) - 32'd1);
   end

   tick_counter #(.W(PHASE_W)) u_phase (
      .clk      (clk),
      .reset    (reset),
      .clr      (~state_valid_s),
      .en       (etick_s),
      .terminal (PHASE_W'(PHASE_TICKS - 1)),
      .count    (phase_cnt_s),
      .done     (phase_done_s)
   );

   tick_counter #(.W(BLINK_W)) u_blink (
      .clk      (clk),
      .reset    (reset),
      .clr      (blink_clr_s),
      .en       (etick_s & flash_s),
      .terminal (blink_term_s),
      .count    (blink_cnt_s),
      .done     (blink_done_s)
   );

   // Advance pulse, one cycle after the terminal tick of a phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         next_r <= 1'b0;
      end else begin
         next_r <= phase_done_s;
      end
   end

   // Blink phase flip-flop; restarts lit whenever the blink divider reinitialises.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_q_r <= 1'b1;
      end else if (blink_clr_s) begin
         blink_q_r <= 1'b1;
      end else if (blink_done_s) begin
         blink_q_r <= ~blink_q_r;
      end else begin
         blink_q_r <= blink_q_r;
      end
   end

   // LED drive decoded directly from the FSM state.
   always_comb begin
      case (state)
         STATE_ON:           light = 1'b1;
         STATE_F1, STATE_F2: light = blink_q_r;
         default:            light = 1'b0;
      endcase
   end

   assign next = next_r;

endmodule
